fft_ctrl: RTL and testbench
===========================

Name: fft_ctrl

Overview:
- Sequencer for an in-place radix-2 decimation-in-frequency FFT built around the registered butterfly unit.
- Walks all LOG2N stages, N/2 butterflies per stage.
- Drives dual read addresses to the sample RAM, the twiddle ROM address, the butterfly enable, and the delayed dual write-back addresses.
- Sits between the acquisition/readout logic (start/done handshake) and the RAM + twiddle ROM + butterfly datapath.

Parameters:
- LOG2N, 4, log2 of FFT length N (N = 2^LOG2N); legal range 2..10.
- PIPE_LAT, 2, cycles from read issue to write-back (1 RAM/ROM read + 1 butterfly register); fixed at 2 for this datapath.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request to run one full FFT; sampled only in IDLE
- busy  out  1  high while a transform is in progress
- done  out  1  one-cycle pulse after the final write-back
- stage  out  4  current stage index, 0..LOG2N-1 (status only)
- rd_en  out  1  RAM read strobe for both ports
- rd_addr_a  out  LOG2N  RAM port A read address
- rd_addr_b  out  LOG2N  RAM port B read address
- tw_addr  out  LOG2N-1  twiddle ROM address, 0..N/2-1
- bf_en  out  1  butterfly enable, equal to rd_en delayed 1 cycle
- wr_en  out  1  RAM write strobe, equal to rd_en delayed PIPE_LAT cycles
- wr_addr_a  out  LOG2N  write address for Xa, equal to rd_addr_a delayed PIPE_LAT
- wr_addr_b  out  LOG2N  write address for Xb, equal to rd_addr_b delayed PIPE_LAT

Behaviour:
- Reset: all outputs 0; state IDLE; stage and butterfly counters 0; delay-line valids cleared.
- Reset mid-run: no wr_en or bf_en is produced after the reset edge. rst wins over start in the same cycle.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start=1 go to RUN; s=0, k=0, busy=1 from the next cycle.
  - RUN: rd_en=1 every cycle, and k increments. After k = N/2-1 go to DRAIN.
  - DRAIN: rd_en=0 for exactly PIPE_LAT cycles, so all stage writes commit before the next stage reads (no RAW hazard). Then:
    - if s < LOG2N-1: s++, k=0, go to RUN;
    - else go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start while busy is ignored; no queuing.
- Address generation for stage s, butterfly k:
  - span = N >> (s+1)
  - j = k mod span
  - a = (k div span)*2*span + j
  - b = a + span
  - tw = j << s
  - Use shifts and masks only; no dividers.
- Latency with start sampled at edge 0:
  - first rd_en at cycle 1;
  - each stage takes N/2 + PIPE_LAT cycles;
  - last wr_en at cycle LOG2N*(N/2+PIPE_LAT);
  - done the following cycle.
  - For N=16: last wr_en at cycle 40, done at cycle 41.
- bf_en, wr_en and wr_addr_* come from a PIPE_LAT-deep shift register of {valid, a, b}. Outputs are registered; rd_addr_* and tw_addr are valid in the same cycle as rd_en.
- When their strobe is low, address outputs hold their last value. Bench must not check them then.

Decomposition:
- fft_pkg.vh holds:
  - state encodings (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - PIPE_LAT;
  - default LOG2N;
  - derived localparams N and HALF_N.
- Sub-module fft_addr_gen (combinational): in stage and k; out a, b, tw.
  - Reused later by the readout bit-reversal logic.
- fft_ctrl holds the FSM, counters and delay line.

Test Plan:
- Reset, then start pulse, LOG2N=4:
  - cycle 1: rd_en=1, a=0, b=8, tw=0;
  - cycle 2: a=1, b=9, tw=1;
  - cycle 8: a=7, b=15, tw=7;
  - cycles 9-10: rd_en=0.
- Stage 1: read sequence is (0,4,0), (1,5,2), (2,6,4), (3,7,6), (8,12,0), (9,13,2), (10,14,4), (11,15,6) at cycles 11-18.
- Stage 3: pairs (0,1), (2,3), …, (14,15), with tw=0 throughout.
- Full run:
  - 32 rd_en, 32 bf_en and 32 wr_en cycles;
  - every wr_addr pair equals the rd pair 2 cycles earlier;
  - bf_en equals rd_en delayed 1;
  - last wr_en at cycle 40, single done pulse at 41, busy low at 41.
- start re-asserted at cycles 5 and 30: ignored, done still exactly once at 41. A start at cycle 42 begins a new run with rd_en at cycle 43.
- rst asserted at cycle 20:
  - from cycle 21 all outputs are 0, with no wr_en or done;
  - a subsequent start runs the full 40-cycle sequence.
- LOG2N=2:
  - reads (0,2,0), (1,3,1), then (0,1,0), (2,3,0);
  - done at cycle 9.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared encodings and sizing for the radix-2 DIF FFT sequencer.
package fft_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Read-to-write-back latency: one RAM/ROM read plus one butterfly register.
   localparam int unsigned PIPE_LAT  = 2;
   localparam int unsigned DEF_LOG2N = 4;
   localparam int unsigned N         = 32'd1 << DEF_LOG2N;
   localparam int unsigned HALF_N    = N / 2;
   localparam int unsigned STAGE_W   = 4;
   localparam int unsigned DRAIN_W   = 2;

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address generator: maps (stage, butterfly index) to the two
// in-place operand addresses and the twiddle index, using masks and shifts.
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int unsigned LOG2N = DEF_LOG2N
) (
   input  logic [STAGE_W-1:0] i_stage,
   input  logic [LOG2N-2:0]   i_k,
   output logic [LOG2N-1:0]   o_a,
   output logic [LOG2N-1:0]   o_b,
   output logic [LOG2N-2:0]   o_tw
);

   localparam int unsigned HALF_PTS = 32'd1 << (LOG2N - 1);

   logic [LOG2N-1:0] w_k;
   logic [LOG2N-1:0] w_span;
   logic [LOG2N-1:0] w_mask;
   logic [LOG2N-1:0] w_j;

   // span = N >> (s+1); group base is the high part of k doubled, j the low part
   always_comb begin
      w_k    = {1'b0, i_k};
      w_span = LOG2N'(HALF_PTS) >> i_stage;
      w_mask = w_span - LOG2N'(1);
      w_j    = w_k & w_mask;
      o_a    = ((w_k & ~w_mask) << 1) | w_j;
      o_b    = o_a | w_span;
      o_tw   = (LOG2N-1)'(w_j << i_stage);
   end

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIF FFT sequencer: walks every stage, issues dual reads
// and twiddle addresses, and replays them as write-back addresses after the
// datapath latency. Each stage drains fully before the next one reads.
module fft_ctrl
   import fft_pkg::*;
#(
   parameter int unsigned LOG2N = DEF_LOG2N
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [STAGE_W-1:0] stage,
   output logic               rd_en,
   output logic [LOG2N-1:0]   rd_addr_a,
   output logic [LOG2N-1:0]   rd_addr_b,
   output logic [LOG2N-2:0]   tw_addr,
   output logic               bf_en,
   output logic               wr_en,
   output logic [LOG2N-1:0]   wr_addr_a,
   output logic [LOG2N-1:0]   wr_addr_b
);

   localparam int unsigned K_W      = LOG2N - 1;
   localparam int unsigned HALF_PTS = 32'd1 << (LOG2N - 1);

   typedef struct packed {
      logic             v;
      logic [LOG2N-1:0] a;
      logic [LOG2N-1:0] b;
   } pipe_t;

   state_t               r_state;
   logic [STAGE_W-1:0]   r_s;
   logic [K_W-1:0]       r_k;
   logic [DRAIN_W-1:0]   r_drain;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_rd_en;
   logic [LOG2N-1:0]     r_rd_a;
   logic [LOG2N-1:0]     r_rd_b;
   logic [LOG2N-2:0]     r_tw;
   pipe_t                r_pipe [PIPE_LAT];

   logic [LOG2N-1:0]     w_a;
   logic [LOG2N-1:0]     w_b;
   logic [LOG2N-2:0]     w_tw;

   fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
      .i_stage (r_s),
      .i_k     (r_k),
      .o_a     (w_a),
      .o_b     (w_b),
      .o_tw    (w_tw)
   );

   // Sequencer FSM with stage/butterfly/drain counters and registered read strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_s     <= '0;
         r_k     <= '0;
         r_drain <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rd_en <= 1'b0;
         r_rd_a  <= '0;
         r_rd_b  <= '0;
         r_tw    <= '0;
      end else begin
         r_rd_en <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_RUN;
                  r_s     <= '0;
                  r_k     <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               r_rd_en <= 1'b1;
               r_rd_a  <= w_a;
               r_rd_b  <= w_b;
               r_tw    <= w_tw;
               r_k     <= r_k + K_W'(1);
               if (r_k == K_W'(HALF_PTS - 1)) begin
                  r_state <= ST_DRAIN;
                  r_drain <= '0;
               end
            end
            ST_DRAIN: begin
               if (r_drain == DRAIN_W'(PIPE_LAT - 1)) begin
                  if (r_s < STAGE_W'(LOG2N - 1)) begin
                     r_s     <= r_s + STAGE_W'(1);
                     r_k     <= '0;
                     r_state <= ST_RUN;
                  end else begin
                     r_state <= ST_DONE;
                  end
               end else begin
                  r_drain <= r_drain + DRAIN_W'(1);
               end
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Write-back delay line; addresses only advance with a valid beat so they hold when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(PIPE_LAT); i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0].v <= r_rd_en;
         if (r_rd_en) begin
            r_pipe[0].a <= r_rd_a;
            r_pipe[0].b <= r_rd_b;
         end
         for (int i = 1; i < int'(PIPE_LAT); i++) begin
            r_pipe[i].v <= r_pipe[i-1].v;
            if (r_pipe[i-1].v) begin
               r_pipe[i].a <= r_pipe[i-1].a;
               r_pipe[i].b <= r_pipe[i-1].b;
            end
         end
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign stage     = r_s;
   assign rd_en     = r_rd_en;
   assign rd_addr_a = r_rd_a;
   assign rd_addr_b = r_rd_b;
   assign tw_addr   = r_tw;
   assign bf_en     = r_pipe[0].v;
   assign wr_en     = r_pipe[PIPE_LAT-1].v;
   assign wr_addr_a = r_pipe[PIPE_LAT-1].a;
   assign wr_addr_b = r_pipe[PIPE_LAT-1].b;

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl: N=16 instance for sequencing, addressing,
// start filtering and mid-run reset; N=4 instance for the smallest size.
module tb_fft_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start;
   logic       start2;

   logic       busy, done, rd_en, bf_en, wr_en;
   logic [3:0] stage;
   logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [2:0] tw_addr;

   logic       busy2, done2, rd_en2, bf_en2, wr_en2;
   logic [3:0] stage2;
   logic [1:0] rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;
   logic [0:0] tw_addr2;

   fft_ctrl #(.LOG2N(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
      .bf_en(bf_en), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
   );

   fft_ctrl #(.LOG2N(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .stage(stage2),
      .rd_en(rd_en2), .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .tw_addr(tw_addr2),
      .bf_en(bf_en2), .wr_en(wr_en2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2)
   );

   int checks = 0;
   int errors = 0;

   logic       c_rd [64], c_bf [64], c_wr [64], c_done [64], c_busy [64];
   logic [3:0] c_a [64], c_b [64], c_wa [64], c_wb [64], c_st [64];
   logic [2:0] c_tw [64];

   int s1_a [8] = '{0, 1, 2, 3, 8, 9, 10, 11};
   int s1_b [8] = '{4, 5, 6, 7, 12, 13, 14, 15};
   int s1_t [8] = '{0, 2, 4, 6, 0, 2, 4, 6};

   // Independent reference: schedule and addresses via plain div/mod arithmetic
   function automatic void exp_at(input int lg, input int c, output bit v, output int s,
                                  output int a, output int b, output int tw);
      int half, per, t, r, span, j;
      half = 1 << (lg - 1);
      per  = half + 2;
      v = 1'b0; s = 0; a = 0; b = 0; tw = 0;
      if (c >= 1) begin
         t = c - 1;
         s = t / per;
         r = t % per;
         if (s < lg && r < half) begin
            v    = 1'b1;
            span = (1 << lg) >> (s + 1);
            j    = r % span;
            a    = (r / span) * 2 * span + j;
            b    = a + span;
            tw   = j * (1 << s);
         end
      end
   endfunction

   task automatic sample(input int c);
      c_rd[c] = rd_en;  c_bf[c] = bf_en;  c_wr[c] = wr_en;
      c_done[c] = done; c_busy[c] = busy; c_st[c] = stage;
      c_a[c] = rd_addr_a; c_b[c] = rd_addr_b; c_tw[c] = tw_addr;
      c_wa[c] = wr_addr_a; c_wb[c] = wr_addr_b;
   endtask

   // Starts a run at edge 0 (called at a negedge) and captures cycles 0..ncyc
   task automatic do_run(input int ncyc, input int x1, input int x2, input int rst_at);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      sample(0);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         rst = 1'b0;
         sample(c);
         start = (c == x1 || c == x2);
         rst   = (c == rst_at);
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; start2 = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, rd_en, bf_en, wr_en} !== 5'b0 || stage !== 4'd0) begin
         errors++;
         $display("FAIL reset_ctrl: busy=%b done=%b rd=%b bf=%b wr=%b stage=%0d, want all 0",
                  busy, done, rd_en, bf_en, wr_en, stage);
      end
      checks++;
      if ({rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 18'd0) begin
         errors++;
         $display("FAIL reset_addr: ra=%0d rb=%0d tw=%0d wa=%0d wb=%0d, want 0",
                  rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b);
      end
      checks++;
      if (busy2 !== 1'b0 || rd_en2 !== 1'b0 || done2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_n4: busy=%b rd=%b done=%b, want 0", busy2, rd_en2, done2);
      end
      rst = 1'b0; start = 1'b0; start2 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
         errors++;
         $display("FAIL rst_over_start: busy=%b rd=%b, want 0 0", busy, rd_en);
      end
   endtask

   task automatic test_stage_addr();
      int cyc [3] = '{1, 2, 8};
      int ea [3]  = '{0, 1, 7};
      int eb [3]  = '{8, 9, 15};
      int et [3]  = '{0, 1, 7};
      do_run(41, -1, -1, -1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (c_rd[cyc[i]] !== 1'b1 || c_a[cyc[i]] !== 4'(ea[i]) || c_b[cyc[i]] !== 4'(eb[i]) ||
             c_tw[cyc[i]] !== 3'(et[i])) begin
            errors++;
            $display("FAIL stage0_c%0d: rd=%b a=%0d b=%0d tw=%0d, want 1 %0d %0d %0d", cyc[i],
                     c_rd[cyc[i]], c_a[cyc[i]], c_b[cyc[i]], c_tw[cyc[i]], ea[i], eb[i], et[i]);
         end
      end
      checks++;
      if (c_rd[9] !== 1'b0 || c_rd[10] !== 1'b0) begin
         errors++;
         $display("FAIL stage0_drain: rd9=%b rd10=%b, want 0 0", c_rd[9], c_rd[10]);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (c_rd[11+i] !== 1'b1 || c_a[11+i] !== 4'(s1_a[i]) || c_b[11+i] !== 4'(s1_b[i]) ||
             c_tw[11+i] !== 3'(s1_t[i]) || c_st[11+i] !== 4'd1) begin
            errors++;
            $display("FAIL stage1_c%0d: rd=%b a=%0d b=%0d tw=%0d st=%0d, want 1 %0d %0d %0d 1",
                     11+i, c_rd[11+i], c_a[11+i], c_b[11+i], c_tw[11+i], c_st[11+i],
                     s1_a[i], s1_b[i], s1_t[i]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (c_rd[31+i] !== 1'b1 || c_a[31+i] !== 4'(2*i) || c_b[31+i] !== 4'(2*i+1) ||
             c_tw[31+i] !== 3'd0) begin
            errors++;
            $display("FAIL stage3_c%0d: rd=%b a=%0d b=%0d tw=%0d, want 1 %0d %0d 0",
                     31+i, c_rd[31+i], c_a[31+i], c_b[31+i], c_tw[31+i], 2*i, 2*i+1);
         end
      end
   endtask

   task automatic test_full_run();
      int n_rd = 0, n_bf = 0, n_wr = 0, n_done = 0;
      bit v, v1, v2;
      int s, a, b, tw, s1, a1, b1, t1, s2, a2, b2, t2;
      do_run(41, 4, 29, -1);
      for (int c = 0; c <= 41; c++) begin
         exp_at(4, c, v, s, a, b, tw);
         exp_at(4, c - 1, v1, s1, a1, b1, t1);
         exp_at(4, c - 2, v2, s2, a2, b2, t2);
         n_rd += int'(c_rd[c]); n_bf += int'(c_bf[c]);
         n_wr += int'(c_wr[c]); n_done += int'(c_done[c]);
         checks++;
         if (c_rd[c] !== v || c_bf[c] !== v1 || c_wr[c] !== v2 || c_done[c] !== (c == 41)) begin
            errors++;
            $display("FAIL strobes_c%0d: rd=%b bf=%b wr=%b done=%b, want %b %b %b %b", c,
                     c_rd[c], c_bf[c], c_wr[c], c_done[c], v, v1, v2, c == 41);
         end
         if (v) begin
            checks++;
            if (c_a[c] !== 4'(a) || c_b[c] !== 4'(b) || c_tw[c] !== 3'(tw) || c_st[c] !== 4'(s)) begin
               errors++;
               $display("FAIL rd_addr_c%0d: a=%0d b=%0d tw=%0d st=%0d, want %0d %0d %0d %0d", c,
                        c_a[c], c_b[c], c_tw[c], c_st[c], a, b, tw, s);
            end
         end
         if (v2) begin
            checks++;
            if (c_wa[c] !== 4'(a2) || c_wb[c] !== 4'(b2)) begin
               errors++;
               $display("FAIL wr_addr_c%0d: wa=%0d wb=%0d, want %0d %0d", c, c_wa[c], c_wb[c], a2, b2);
            end
         end
         if (c >= 1) begin
            checks++;
            if (c_busy[c] !== (c <= 40)) begin
               errors++;
               $display("FAIL busy_c%0d: got %b, want %b", c, c_busy[c], c <= 40);
            end
         end
      end
      checks++;
      if (n_rd != 32 || n_bf != 32 || n_wr != 32 || n_done != 1) begin
         errors++;
         $display("FAIL counts: rd=%0d bf=%0d wr=%0d done=%0d, want 32 32 32 1",
                  n_rd, n_bf, n_wr, n_done);
      end
   endtask

   task automatic test_back_to_back();
      int n_wr = 0;
      do_run(41, -1, -1, -1);
      for (int c = 0; c <= 41; c++) n_wr += int'(c_wr[c]);
      checks++;
      if (c_rd[0] !== 1'b0 || c_rd[1] !== 1'b1 || c_a[1] !== 4'd0 || c_b[1] !== 4'd8) begin
         errors++;
         $display("FAIL b2b_first: rd0=%b rd1=%b a=%0d b=%0d, want 0 1 0 8",
                  c_rd[0], c_rd[1], c_a[1], c_b[1]);
      end
      checks++;
      if (c_done[41] !== 1'b1 || c_done[40] !== 1'b0 || n_wr != 32) begin
         errors++;
         $display("FAIL b2b_end: done40=%b done41=%b wr=%0d, want 0 1 32", c_done[40], c_done[41], n_wr);
      end
   endtask

   task automatic test_reset_mid_run();
      int n_wr = 0, n_done = 0;
      do_run(41, -1, -1, 20);
      checks++;
      if (c_wr[20] !== 1'b1 || c_busy[20] !== 1'b1) begin
         errors++;
         $display("FAIL pre_rst_c20: wr=%b busy=%b, want 1 1", c_wr[20], c_busy[20]);
      end
      for (int c = 21; c <= 41; c++) begin
         checks++;
         if ({c_rd[c], c_bf[c], c_wr[c], c_done[c], c_busy[c]} !== 5'b0 || c_st[c] !== 4'd0 ||
             c_a[c] !== 4'd0 || c_b[c] !== 4'd0 || c_tw[c] !== 3'd0 || c_wa[c] !== 4'd0 ||
             c_wb[c] !== 4'd0) begin
            errors++;
            $display("FAIL post_rst_c%0d: rd=%b bf=%b wr=%b done=%b busy=%b st=%0d a=%0d b=%0d wa=%0d, want 0",
                     c, c_rd[c], c_bf[c], c_wr[c], c_done[c], c_busy[c], c_st[c], c_a[c], c_b[c], c_wa[c]);
         end
      end
      do_run(41, -1, -1, -1);
      for (int c = 0; c <= 41; c++) begin
         n_wr += int'(c_wr[c]);
         n_done += int'(c_done[c]);
      end
      checks++;
      if (n_wr != 32 || n_done != 1 || c_wr[40] !== 1'b1 || c_done[41] !== 1'b1) begin
         errors++;
         $display("FAIL rerun: wr=%0d done=%0d wr40=%b done41=%b, want 32 1 1 1",
                  n_wr, n_done, c_wr[40], c_done[41]);
      end
   endtask

   task automatic test_log2n_2();
      int cyc [4] = '{1, 2, 5, 6};
      int ea [4]  = '{0, 1, 0, 2};
      int eb [4]  = '{2, 3, 1, 3};
      int et [4]  = '{0, 1, 0, 0};
      int ri, wi;
      start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      for (int c = 0; c <= 11; c++) begin
         if (c > 0) @(negedge clk);
         ri = -1; wi = -1;
         for (int i = 0; i < 4; i++) begin
            if (cyc[i] == c) ri = i;
            if (cyc[i] == c - 2) wi = i;
         end
         checks++;
         if (rd_en2 !== (ri >= 0) || wr_en2 !== (wi >= 0) || done2 !== (c == 9)) begin
            errors++;
            $display("FAIL n4_strobes_c%0d: rd=%b wr=%b done=%b, want %b %b %b",
                     c, rd_en2, wr_en2, done2, ri >= 0, wi >= 0, c == 9);
         end
         if (ri >= 0) begin
            checks++;
            if (rd_addr_a2 !== 2'(ea[ri]) || rd_addr_b2 !== 2'(eb[ri]) || tw_addr2 !== 1'(et[ri])) begin
               errors++;
               $display("FAIL n4_rd_c%0d: a=%0d b=%0d tw=%0d, want %0d %0d %0d",
                        c, rd_addr_a2, rd_addr_b2, tw_addr2, ea[ri], eb[ri], et[ri]);
            end
         end
         if (wi >= 0) begin
            checks++;
            if (wr_addr_a2 !== 2'(ea[wi]) || wr_addr_b2 !== 2'(eb[wi])) begin
               errors++;
               $display("FAIL n4_wr_c%0d: wa=%0d wb=%0d, want %0d %0d",
                        c, wr_addr_a2, wr_addr_b2, ea[wi], eb[wi]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start2 = 1'b0;
      @(negedge clk);
      test_reset();
      test_stage_addr();
      test_full_run();
      test_back_to_back();
      test_reset_mid_run();
      test_log2n_2();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
